ex_logic_unit: RTL and testbench

- Execute-stage integer unit of the RISC-V core; consumes decoded operands from the register-read stage and produces a registered result for writeback.
- Contains the bitwise ops (AND/OR/XOR), add/sub, set-less-than and shifts.
- Valid/ready handshake on both sides.
- Shifts are iterative, one bit per cycle, to save area; all other ops complete in one cycle.

---
 rtl/ex_pkg.sv | 39 +++
 rtl/ex_shift_iter.sv | 56 +++++
 rtl/ex_logic_unit.sv | 180 ++++++++++++++++++
 tb/tb_ex_logic_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// -----------------------------------------------------------------------------
// ex_pkg
// Shared definitions for the execute-stage logic unit:
//   XLEN_DEF  - default operand/result width
//   OP_*      - 4-bit operation codes (10..15 are illegal)
//   state_t   - FSM state encoding (IDLE / SHIFT)
//   is_shift  - true for SLL/SRL/SRA
//   is_legal  - true for op codes 0..9
// Build option: EX_BARREL_SHIFT_EN (see ex_logic_unit) does not change this file.
// -----------------------------------------------------------------------------
package ex_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLTU = 4'd6;
   localparam logic [3:0] OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8;
   localparam logic [3:0] OP_SRA  = 4'd9;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

   function automatic logic is_legal(input logic [3:0] op);
      return (op <= OP_SRA);
   endfunction

endpackage

// File: rtl/ex_shift_iter.sv
// -----------------------------------------------------------------------------
// ex_shift_iter
// Bit-serial shifter used by ex_logic_unit in the iterative build. Holds the
// value being shifted, the remaining shift count and the shift kind.
//   clk, rst_n  - clock, async active-low reset
//   i_load      - capture i_a / i_amt / i_op (start of a shift)
//   i_step      - perform one 1-bit shift and decrement the count
//   i_op        - OP_SLL / OP_SRL / OP_SRA
//   i_a, i_amt  - value to shift and shift amount (amount > 0)
//   o_next      - value after one more shift step (combinational)
//   o_last      - the step taken this cycle is the final one (count == 1)
// -----------------------------------------------------------------------------
module ex_shift_iter
   import ex_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_load,
   input  logic            i_step,
   input  logic [3:0]      i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [SHW-1:0]  i_amt,
   output logic [XLEN-1:0] o_next,
   output logic            o_last
);

   logic [XLEN-1:0] r_val;
   logic [SHW-1:0]  r_cnt;
   logic [3:0]      r_op;
   logic            w_fill;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_val <= '0;
         r_cnt <= '0;
         r_op  <= OP_SLL;
      end else if (i_load) begin
         r_val <= i_a;
         r_cnt <= i_amt;
         r_op  <= i_op;
      end else if (i_step) begin
         r_val <= o_next;
         r_cnt <= r_cnt - 1'b1;
      end
   end

   // SRA replicates the sign of the value as it currently stands.
   assign w_fill = (r_op == OP_SRA) ? r_val[XLEN-1] : 1'b0;
   assign o_next = (r_op == OP_SLL) ? {r_val[XLEN-2:0], 1'b0}
                                    : {w_fill, r_val[XLEN-1:1]};
   assign o_last = (r_cnt == SHW'(1));

endmodule

// File: rtl/ex_logic_unit.sv
// -----------------------------------------------------------------------------
// ex_logic_unit
// Execute-stage integer unit: ADD/SUB/AND/OR/XOR/SLT/SLTU single cycle,
// SLL/SRL/SRA iterative (one bit per cycle) or single cycle with
// EX_BARREL_SHIFT_EN defined. Result is registered for writeback.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   in_valid / in_ready   - input handshake, accept = in_valid && in_ready
//   in_op, in_a, in_b     - op code and operands; shift amount = in_b[SHW-1:0]
//   out_valid / out_ready - output handshake; result regs hold while stalled
//   out_result, out_err   - registered result, illegal-op flag
//   busy                  - iterative shift in progress (0 in barrel build)
// Handshake: a transfer happens on any rising edge where valid and ready are
// both high; the producer holds its payload stable until then, and ready may
// depend combinationally on the consumer's ready (in_ready uses out_ready).
// Build option: EX_BARREL_SHIFT_EN - single-cycle barrel shifter, no SHIFT state.
// -----------------------------------------------------------------------------
module ex_logic_unit
   import ex_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   localparam int SHW = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            out_err,
   output logic            busy
);

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_out_valid;
   logic [XLEN-1:0] r_out_result;
   logic            r_out_err;

   logic            w_accept;
   logic [SHW-1:0]  w_amt;
   logic            w_slt;
   logic            w_sltu;
   logic [XLEN-1:0] w_alu_res;
   logic            w_wr;
   logic [XLEN-1:0] w_wr_res;
   logic            w_wr_err;

`ifndef EX_BARREL_SHIFT_EN
   logic            w_load;
   logic            w_step;
   logic [XLEN-1:0] w_sh_next;
   logic            w_sh_last;
`endif

   assign w_amt    = in_b[SHW-1:0];
   assign w_slt    = $signed(in_a) < $signed(in_b);
   assign w_sltu   = in_a < in_b;

   // New work only in IDLE, and only if the result slot is free or drains now.
   assign in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   // Single-cycle result path.
   always_comb begin
      w_alu_res = '0;
      case (in_op)
         OP_ADD:  w_alu_res = in_a + in_b;
         OP_SUB:  w_alu_res = in_a - in_b;
         OP_AND:  w_alu_res = in_a & in_b;
         OP_OR:   w_alu_res = in_a | in_b;
         OP_XOR:  w_alu_res = in_a ^ in_b;
         OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, w_slt};
         OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, w_sltu};
`ifdef EX_BARREL_SHIFT_EN
         OP_SLL:  w_alu_res = in_a << w_amt;
         OP_SRL:  w_alu_res = in_a >> w_amt;
         OP_SRA:  w_alu_res = $unsigned($signed(in_a) >>> w_amt);
`else
         // Reached only for a zero shift amount; non-zero goes iterative.
         OP_SLL, OP_SRL, OP_SRA: w_alu_res = in_a;
`endif
         default: w_alu_res = '0;
      endcase
   end

`ifndef EX_BARREL_SHIFT_EN
   ex_shift_iter #(
      .XLEN (XLEN),
      .SHW  (SHW)
   ) u_shift_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_step (w_step),
      .i_op   (in_op),
      .i_a    (in_a),
      .i_amt  (w_amt),
      .o_next (w_sh_next),
      .o_last (w_sh_last)
   );
`endif

   // Next-state and result-write control.
   always_comb begin
      w_state_nxt = r_state;
      w_wr        = 1'b0;
      w_wr_res    = '0;
      w_wr_err    = 1'b0;
`ifndef EX_BARREL_SHIFT_EN
      w_load      = 1'b0;
      w_step      = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
`ifndef EX_BARREL_SHIFT_EN
               if (is_shift(in_op) && (w_amt != '0)) begin
                  w_load      = 1'b1;
                  w_state_nxt = ST_SHIFT;
               end else begin
                  w_wr     = 1'b1;
                  w_wr_res = w_alu_res;
                  w_wr_err = !is_legal(in_op);
               end
`else
               w_wr     = 1'b1;
               w_wr_res = w_alu_res;
               w_wr_err = !is_legal(in_op);
`endif
            end
         end
`ifndef EX_BARREL_SHIFT_EN
         ST_SHIFT: begin
            w_step = 1'b1;
            // The final step goes straight into the result register; in_ready
            // guaranteed the slot was free when the shift started.
            if (w_sh_last) begin
               w_wr        = 1'b1;
               w_wr_res    = w_sh_next;
               w_state_nxt = ST_IDLE;
            end
         end
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_wr) begin
            r_out_valid  <= 1'b1;
            r_out_result <= w_wr_res;
            r_out_err    <= w_wr_err;
         end else if (out_ready) begin
            r_out_valid  <= 1'b0;
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign out_err    = r_out_err;
`ifdef EX_BARREL_SHIFT_EN
   assign busy       = 1'b0;
`else
   assign busy       = (r_state == ST_SHIFT);
`endif

endmodule

// File: tb/tb_ex_logic_unit.sv
// -----------------------------------------------------------------------------
// tb_ex_logic_unit
// Directed and randomized checks of ex_logic_unit (iterative build) against a
// behavioural reference model computed from the op definitions.
// -----------------------------------------------------------------------------
module tb_ex_logic_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_err;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic [32:0] exp_q[$];

   ex_logic_unit #(.XLEN(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_err    (out_err),
      .busy       (busy)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- checkers ----------------
   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   // ---------------- reference model ----------------
   // Returns {err, result}.
   function automatic logic [32:0] ref_model(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      int     sh;
      longint sa;
      longint sb;
      sh = int'(b[4:0]);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         4'd0: return {1'b0, a + b};
         4'd1: return {1'b0, a - b};
         4'd2: return {1'b0, a & b};
         4'd3: return {1'b0, a | b};
         4'd4: return {1'b0, a ^ b};
         4'd5: return {1'b0, (sa < sb) ? 32'd1 : 32'd0};
         4'd6: return {1'b0, ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0};
         4'd7: return {1'b0, a << sh};
         4'd8: return {1'b0, a >> sh};
         // Arithmetic right shift of a negative value == NOT(logical shift of NOT a).
         4'd9: return {1'b0, a[31] ? ~((~a) >> sh) : (a >> sh)};
         default: return {1'b1, 32'd0};
      endcase
   endfunction

   function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
      if ((op >= 4'd7) && (op <= 4'd9) && (b[4:0] != 5'd0))
         return int'(b[4:0]) + 1;
      return 1;
   endfunction

   // ---------------- driver ----------------
   // Issues one op with out_ready=1, waits for the result, checks value,
   // error flag, latency and busy duration.
   task automatic run_op(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic err);
      int          lat;
      int          nbusy;
      int          exp_lat;
      logic [32:0] e;
      exp_lat = ref_latency(op, b);
      @(negedge clk);
      in_op     = op;
      in_a      = a;
      in_b      = b;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      chk1({tag, "_in_ready"}, in_ready, 1'b1);
      @(posedge clk);
      exp_q.push_back(ref_model(op, a, b));
      #1;
      in_valid = 1'b0;
      // Scramble operands: a shift in flight must use the captured values.
      in_a  = $urandom;
      in_b  = $urandom;
      in_op = 4'($urandom_range(0, 15));
      lat   = 0;
      nbusy = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
         if (busy) nbusy++;
      end
      res = out_result;
      err = out_err;
      chk1({tag, "_valid"}, out_valid, 1'b1);
      if (out_valid && (exp_q.size() > 0)) begin
         e = exp_q.pop_front();
         chk32({tag, "_result"}, out_result, e[31:0]);
         chk1({tag, "_err"}, out_err, e[32]);
         chk32({tag, "_latency"}, 32'(lat), 32'(exp_lat));
         chk32({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_lat - 1));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] r;
      logic        er;
      logic        stale;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 4'd0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk32("rst_out_result", out_result, 32'd0);
      chk1("rst_out_err", out_err, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk1("rst_in_ready", in_ready, 1'b1);

      // Single-cycle ops.
      run_op("or", 4'd3, 32'h0F0F0000, 32'h00F0F00F, r, er);
      chk32("or_value", r, 32'h0FFFF00F);
      run_op("sub", 4'd1, 32'd5, 32'd7, r, er);
      chk32("sub_value", r, 32'hFFFFFFFE);
      run_op("slt", 4'd5, 32'hFFFFFFFF, 32'd1, r, er);
      chk32("slt_value", r, 32'd1);
      run_op("sltu", 4'd6, 32'hFFFFFFFF, 32'd1, r, er);
      chk32("sltu_value", r, 32'd0);

      // Iterative shifts.
      run_op("sra4", 4'd9, 32'h80000000, 32'd4, r, er);
      chk32("sra4_value", r, 32'hF8000000);
      run_op("srl4", 4'd8, 32'h80000000, 32'd4, r, er);
      chk32("srl4_value", r, 32'h08000000);
      run_op("sll0", 4'd7, 32'd1, 32'd0, r, er);
      chk32("sll0_value", r, 32'd1);
      run_op("sll31", 4'd7, 32'd1, 32'd31, r, er);
      chk32("sll31_value", r, 32'h80000000);

      // Illegal op, then a legal op clears the error flag.
      run_op("illegal", 4'd12, 32'h12345678, 32'h9ABCDEF0, r, er);
      chk1("illegal_err", er, 1'b1);
      chk32("illegal_value", r, 32'd0);
      run_op("after_illegal", 4'd2, 32'hFF00FF00, 32'h0FF00FF0, r, er);
      chk1("after_illegal_err", er, 1'b0);

      // Backpressure.
      @(negedge clk);
      in_op     = 4'd0;
      in_a      = 32'd100;
      in_b      = 32'd23;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk1("bp_first_valid", out_valid, 1'b1);
      chk32("bp_first_result", out_result, 32'd123);
      in_op    = 4'd4;
      in_a     = 32'h000000FF;
      in_b     = 32'h0000000F;
      in_valid = 1'b1;
      #1;
      chk1("bp_in_ready_low", in_ready, 1'b0);
      repeat (2) begin
         @(negedge clk);
         chk1("bp_hold_valid", out_valid, 1'b1);
         chk32("bp_hold_result", out_result, 32'd123);
         chk1("bp_hold_in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      #1;
      chk1("bp_in_ready_release", in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk1("bp_second_valid", out_valid, 1'b1);
      chk32("bp_second_result", out_result, 32'h000000F0);
      chk1("bp_second_err", out_err, 1'b0);

      // Reset in the middle of a 10-bit SLL.
      @(negedge clk);
      in_op    = 4'd7;
      in_a     = 32'd1;
      in_b     = 32'd10;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk1("mid_busy", busy, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk1("mid_rst_valid", out_valid, 1'b0);
      chk1("mid_rst_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk1("mid_rel_in_ready", in_ready, 1'b1);
      stale = 1'b0;
      repeat (14) begin
         @(negedge clk);
         stale = stale | out_valid | busy;
      end
      chk1("mid_no_stale", stale, 1'b0);

      // Randomized ops against the model.
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 1) == 1) b[4:0] = 5'($urandom_range(0, 3));
         run_op("rand", op, a, b, r, er);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
